// File: rtl/orbit_cnt_capture_reg_pkg.sv
// rtl/orbit_cnt_capture_reg_pkg.sv - shared bunch/orbit counter constants, snapshot type and delta helper
package orbit_cnt_capture_reg_pkg;

  localparam logic [11:0] LSB_CNT_MAX = 12'd3563;
  localparam logic        ZERO        = 1'b0;
  localparam logic        ONE         = 1'b1;

  typedef struct packed {
    logic [2:0]  msb;
    logic [11:0] lsb;
    logic [11:0] delta;
  } snap_t;

  // Valid only when the two captures are at most one orbit step apart.
  function automatic logic [11:0] cnt_delta(input logic [11:0] lsb, input logic [2:0] msb,
                                            input logic [11:0] prev_lsb,
                                            input logic [2:0] prev_msb);
    if (msb == prev_msb) return lsb - prev_lsb;
    return lsb + LSB_CNT_MAX - prev_lsb;
  endfunction

endpackage

// File: rtl/orbit_cnt_capture_reg_snap_fifo2.sv
// rtl/orbit_cnt_capture_reg_snap_fifo2.sv - 2-entry valid/ready FIFO of snapshots
module snap_fifo2
  import orbit_cnt_capture_reg_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  clr_i,
  input  logic  push_i,
  input  snap_t push_data_i,
  input  logic  pop_i,
  output logic  valid_o,
  output snap_t head_o,
  output logic  full_o,
  output logic  empty_o
);

  snap_t       mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        pop;
  logic        push;

  assign empty_o = (count == 2'd0);
  assign full_o  = (count == 2'd2);
  assign valid_o = ~empty_o;
  assign head_o  = mem[rd_ptr];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign pop  = pop_i & ~empty_o;
  assign push = push_i & (~full_o | pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= ZERO;
      rd_ptr <= ZERO;
      count  <= 2'd0;
    end else if (clr_i) begin
      wr_ptr <= ZERO;
      rd_ptr <= ZERO;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !clr_i) mem[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/orbit_cnt_capture_reg.sv
// rtl/orbit_cnt_capture_reg.sv - bunch/orbit count register with sticky error and snapshot capture FIFO
module orbit_cnt_capture_reg
  import orbit_cnt_capture_reg_pkg::*;
#(
  parameter int LSB_W = 12,
  parameter int MSB_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             err_clr_i,
  input  logic [LSB_W-1:0] next_lsb_cnt_i,
  input  logic [MSB_W-1:0] next_msb_cnt_i,
  input  logic             lsb_cnt_err_i,
  output logic [LSB_W-1:0] lsb_cnt_o,
  output logic [MSB_W-1:0] msb_cnt_o,
  output logic             err_o,
  input  logic             capture_i,
  output logic             snap_valid_o,
  input  logic             snap_ready_i,
  output logic [LSB_W-1:0] snap_lsb_o,
  output logic [MSB_W-1:0] snap_msb_o,
  output logic [LSB_W-1:0] snap_delta_o,
  output logic             snap_ovf_o
);

  logic [LSB_W-1:0] prev_lsb;
  logic [MSB_W-1:0] prev_msb;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             cap;
  logic             push_ok;
  logic             drop;
  snap_t            push_data;
  snap_t            head;

  assign pop     = snap_valid_o & snap_ready_i;
  assign cap     = capture_i & ~clr_i;
  assign push_ok = cap & (~fifo_full | pop);
  assign drop    = cap & fifo_full & ~pop;

  // Capture always sees the count before any same-cycle load.
  assign push_data.msb   = msb_cnt_o;
  assign push_data.lsb   = lsb_cnt_o;
  assign push_data.delta = cnt_delta(lsb_cnt_o, msb_cnt_o, prev_lsb, prev_msb);

  assign snap_lsb_o   = head.lsb;
  assign snap_msb_o   = head.msb;
  assign snap_delta_o = head.delta;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lsb_cnt_o  <= '0;
      msb_cnt_o  <= '0;
      err_o      <= ZERO;
      snap_ovf_o <= ZERO;
      prev_lsb   <= '0;
      prev_msb   <= '0;
    end else if (clr_i) begin
      lsb_cnt_o  <= '0;
      msb_cnt_o  <= '0;
      err_o      <= ZERO;
      snap_ovf_o <= ZERO;
      prev_lsb   <= '0;
      prev_msb   <= '0;
    end else begin
      if (en_i) begin
        lsb_cnt_o <= next_lsb_cnt_i;
        msb_cnt_o <= next_msb_cnt_i;
      end
      if (err_clr_i)                  err_o <= ZERO;
      else if (en_i && lsb_cnt_err_i) err_o <= ONE;
      if (push_ok) begin
        prev_lsb <= lsb_cnt_o;
        prev_msb <= msb_cnt_o;
      end
      if (drop) snap_ovf_o <= ONE;
    end
  end

  snap_fifo2 u_snap_fifo2 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (clr_i),
    .push_i      (push_ok),
    .push_data_i (push_data),
    .pop_i       (snap_ready_i),
    .valid_o     (snap_valid_o),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_orbit_cnt_capture_reg.sv
// tb/tb_orbit_cnt_capture_reg.sv - scoreboard bench for orbit_cnt_capture_reg
module tb_orbit_cnt_capture_reg;
  import orbit_cnt_capture_reg_pkg::*;

  logic        clk_i, rst_ni, en_i, clr_i, err_clr_i, lsb_cnt_err_i;
  logic [11:0] next_lsb_cnt_i, lsb_cnt_o, snap_lsb_o, snap_delta_o;
  logic [2:0]  next_msb_cnt_i, msb_cnt_o, snap_msb_o;
  logic        err_o, capture_i, snap_valid_o, snap_ready_i, snap_ovf_o;

  orbit_cnt_capture_reg #(.LSB_W(12), .MSB_W(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .clr_i(clr_i), .err_clr_i(err_clr_i),
    .next_lsb_cnt_i(next_lsb_cnt_i), .next_msb_cnt_i(next_msb_cnt_i),
    .lsb_cnt_err_i(lsb_cnt_err_i), .lsb_cnt_o(lsb_cnt_o), .msb_cnt_o(msb_cnt_o),
    .err_o(err_o), .capture_i(capture_i), .snap_valid_o(snap_valid_o),
    .snap_ready_i(snap_ready_i), .snap_lsb_o(snap_lsb_o), .snap_msb_o(snap_msb_o),
    .snap_delta_o(snap_delta_o), .snap_ovf_o(snap_ovf_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int          checks = 0;
  int          failures = 0;
  snap_t       exp_q[$];
  logic [11:0] m_lsb, m_plsb, last_delta;
  logic [2:0]  m_msb, m_pmsb;
  logic        m_err, m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_lsb = '0; m_msb = '0; m_err = 1'b0; m_ovf = 1'b0; m_plsb = '0; m_pmsb = '0;
    exp_q.delete();
  endtask

  // One clock: check outputs at negedge, score handshakes, advance the model.
  task automatic cyc();
    snap_t e;
    int    d;
    @(negedge clk_i);
    check_eq("lsb_cnt", 32'(lsb_cnt_o), 32'(m_lsb));
    check_eq("msb_cnt", 32'(msb_cnt_o), 32'(m_msb));
    check_eq("err", 32'(err_o), 32'(m_err));
    check_eq("snap_ovf", 32'(snap_ovf_o), 32'(m_ovf));
    check_eq("snap_valid", 32'(snap_valid_o), 32'(exp_q.size() != 0));
    if (snap_ready_i && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("snap_lsb", 32'(snap_lsb_o), 32'(e.lsb));
      check_eq("snap_msb", 32'(snap_msb_o), 32'(e.msb));
      check_eq("snap_delta", 32'(snap_delta_o), 32'(e.delta));
      last_delta = snap_delta_o;
    end
    if (capture_i && !clr_i) begin
      if (exp_q.size() < 2) begin
        d = int'(m_lsb) + ((m_msb != m_pmsb) ? 3563 : 0) - int'(m_plsb);
        e.lsb = m_lsb; e.msb = m_msb; e.delta = 12'(d & 4095);
        exp_q.push_back(e);
        m_plsb = m_lsb; m_pmsb = m_msb;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (clr_i) begin
      model_reset();
    end else begin
      if (err_clr_i) m_err = 1'b0;
      else if (en_i && lsb_cnt_err_i) m_err = 1'b1;
      if (en_i) begin
        m_lsb = next_lsb_cnt_i; m_msb = next_msb_cnt_i;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic load(input logic [11:0] l, input logic [2:0] m, input logic e);
    en_i = 1'b1; next_lsb_cnt_i = l; next_msb_cnt_i = m; lsb_cnt_err_i = e;
    cyc();
    en_i = 1'b0; lsb_cnt_err_i = 1'b0;
  endtask

  task automatic capture_once();
    capture_i = 1'b1;
    cyc();
    capture_i = 1'b0;
  endtask

  task automatic clear();
    clr_i = 1'b1;
    cyc();
    clr_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; en_i = 1'b0; clr_i = 1'b0; err_clr_i = 1'b0; lsb_cnt_err_i = 1'b0;
    next_lsb_cnt_i = '0; next_msb_cnt_i = '0; capture_i = 1'b0; snap_ready_i = 1'b0;
    last_delta = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    cyc();

    // asynchronous reset mid-count
    load(12'd100, 3'd0, 1'b0);
    check_eq("load_100", 32'(lsb_cnt_o), 32'd100);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("rst_lsb", 32'(lsb_cnt_o), 32'd0);
    check_eq("rst_valid", 32'(snap_valid_o), 32'd0);
    check_eq("rst_ovf", 32'(snap_ovf_o), 32'd0);
    model_reset();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    load(12'd1, 3'd0, 1'b0);
    check_eq("lsb_after_rst", 32'(lsb_cnt_o), 32'd1);

    // orbit step and cross-MSB delta
    clear();
    load(12'd3000, 3'd2, 1'b0);
    capture_once();
    snap_ready_i = 1'b1; cyc(); snap_ready_i = 1'b0;
    load(12'd3563, 3'd2, 1'b0);
    load(12'd0, 3'd3, 1'b0);
    check_eq("wrap_lsb", 32'(lsb_cnt_o), 32'd0);
    check_eq("wrap_msb", 32'(msb_cnt_o), 32'd3);
    load(12'd10, 3'd3, 1'b0);
    capture_once();
    snap_ready_i = 1'b1; cyc(); snap_ready_i = 1'b0;
    check_eq("delta_cross", 32'(last_delta), 32'd573);

    // same-MSB deltas with consumer always ready
    clear();
    snap_ready_i = 1'b1;
    load(12'd0, 3'd1, 1'b0);
    capture_once(); cyc();
    load(12'd200, 3'd1, 1'b0);
    capture_once(); cyc();
    check_eq("delta_200", 32'(last_delta), 32'd200);
    load(12'd450, 3'd1, 1'b0);
    capture_once(); cyc();
    check_eq("delta_250", 32'(last_delta), 32'd250);
    cyc();
    snap_ready_i = 1'b0;

    // overflow: third capture dropped, reference stays at the second
    clear();
    load(12'd10, 3'd0, 1'b0); capture_once();
    load(12'd20, 3'd0, 1'b0); capture_once();
    load(12'd30, 3'd0, 1'b0); capture_once();
    check_eq("ovf_set", 32'(snap_ovf_o), 32'd1);
    snap_ready_i = 1'b1; cyc(); cyc(); snap_ready_i = 1'b0;
    load(12'd50, 3'd0, 1'b0); capture_once();
    snap_ready_i = 1'b1; cyc(); snap_ready_i = 1'b0;
    check_eq("delta_after_drop", 32'(last_delta), 32'd30);
    check_eq("ovf_sticky", 32'(snap_ovf_o), 32'd1);

    // full FIFO with simultaneous pop and push
    clear();
    load(12'd5, 3'd0, 1'b0); capture_once();
    load(12'd6, 3'd0, 1'b0); capture_once();
    load(12'd7, 3'd0, 1'b0);
    snap_ready_i = 1'b1;
    capture_once();
    cyc(); cyc(); cyc();
    snap_ready_i = 1'b0;
    check_eq("ovf_clear_popush", 32'(snap_ovf_o), 32'd0);
    check_eq("delta_7", 32'(last_delta), 32'd1);

    // sticky error and clear priority
    load(12'd8, 3'd0, 1'b1);
    check_eq("err_set", 32'(err_o), 32'd1);
    cyc();
    check_eq("err_hold", 32'(err_o), 32'd1);
    err_clr_i = 1'b1;
    load(12'd9, 3'd0, 1'b1);
    err_clr_i = 1'b0;
    check_eq("err_clr_wins", 32'(err_o), 32'd0);

    // clear with same-cycle capture
    load(12'd40, 3'd1, 1'b0);
    clr_i = 1'b1; capture_i = 1'b1;
    cyc();
    clr_i = 1'b0; capture_i = 1'b0;
    check_eq("clr_lsb", 32'(lsb_cnt_o), 32'd0);
    check_eq("clr_valid", 32'(snap_valid_o), 32'd0);
    check_eq("clr_ovf", 32'(snap_ovf_o), 32'd0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/orbit_cnt_capture_reg.md
Name: orbit_cnt_capture_reg

Overview:
- Register and capture stage wrapped around the combinational next-count logic of the two-level bunch/orbit counter.
- Holds the current 12-bit LSB and 3-bit MSB count and feeds them to the next-count logic.
- Loads the returned next values and keeps a sticky LSB-overflow error.
- On a capture strobe, timestamps the current count into a 2-entry snapshot FIFO with a valid/ready read port. Each entry carries the delta to the previous accepted capture.

Parameters:
- LSB_W, 12, LSB counter width (must match the package constant type).
- MSB_W, 3, MSB counter width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- en_i  in  1  count enable: load next values this cycle
- clr_i  in  1  synchronous clear: counter, error, FIFO, delta reference
- err_clr_i  in  1  clears sticky error only
- next_lsb_cnt_i  in  12  next LSB from next-count logic
- next_msb_cnt_i  in  3  next MSB from next-count logic
- lsb_cnt_err_i  in  1  out-of-range flag from next-count logic
- lsb_cnt_o  out  12  registered LSB count, to next-count logic
- msb_cnt_o  out  3  registered MSB count, to next-count logic
- err_o  out  1  sticky count error
- capture_i  in  1  single-cycle capture strobe
- snap_valid_o  out  1  FIFO head valid
- snap_ready_i  in  1  consumer accepts head
- snap_lsb_o  out  12  head LSB
- snap_msb_o  out  3  head MSB
- snap_delta_o  out  12  head delta to previous capture
- snap_ovf_o  out  1  sticky capture dropped (FIFO full)

Behaviour:
- Reset (rst_ni=0, asynchronous) drives all registered outputs to 0: lsb_cnt_o, msb_cnt_o, err_o, snap_valid_o, snap_ovf_o. It also zeroes the FIFO pointers and the delta reference (prev_lsb, prev_msb).
- Counter:
  - clr_i=1 sets lsb/msb to 0 next cycle.
  - Otherwise, en_i=1 loads next_lsb_cnt_i/next_msb_cnt_i.
  - Otherwise, the counter holds.
  - Latency: one cycle from en_i to the updated lsb_cnt_o.
- MSB wrap (7 to 1 step to 0) is performed upstream; this block loads whatever it is given.
- Error:
  - err_o sets on en_i & lsb_cnt_err_i.
  - clr_i or err_clr_i clears it; clear wins over a same-cycle set.
- Capture:
  - capture_i samples the current registered count, i.e. the value before any same-cycle en_i update.
  - Delta rule: if msb == prev_msb, delta = lsb - prev_lsb. Otherwise, delta = (lsb + LSB_CNT_MAX) - prev_lsb.
  - Delta arithmetic is truncated to 12 bits. The rule is valid only for a one-MSB-step separation; larger gaps are not flagged.
  - On an accepted push, prev_lsb and prev_msb update to the captured value.
- FIFO: 2 entries, each holding {msb, lsb, delta}. The head is presented combinationally from storage.
  - Pop occurs when snap_valid_o & snap_ready_i.
  - Push is accepted if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Full with no pop: the capture is dropped, snap_ovf_o sets, and prev_* is not updated.
  - Empty with a same-cycle push: snap_valid_o rises the next cycle; there is no fall-through.
- snap_ovf_o clears only on clr_i or reset.
- clr_i also empties the FIFO and zeroes prev_*. A capture_i in the same cycle as clr_i is ignored and does not set snap_ovf_o.
- snap_ready_i while empty has no effect.

Decomposition:
- Shared package (the existing project package) holds:
  - LSB_CNT_MAX (12'd3563);
  - ZERO/ONE;
  - typedef snap_t {logic [2:0] msb; logic [11:0] lsb; logic [11:0] delta}.
- The delta computation is a package function cnt_delta(lsb, msb, prev_lsb, prev_msb), reused by other capture points.
- One sub-module is natural: snap_fifo2, a generic 2-entry valid/ready FIFO of snap_t exposing full/empty.

Test Plan:
- Reset mid-count at lsb=100 -> all outputs 0 asynchronously; after release with en_i=1 and next values 1/0 -> lsb_cnt_o=1 one cycle later.
- Run the counter to lsb=3563, msb=2, then step -> upstream next (0,3) loaded; capture at (10,3) after a prior capture at (3000,2) -> delta = 10+3563-3000 = 573.
- Same-MSB captures at (200,1) then (450,1), with snap_ready_i=1 -> two pops with deltas 200 then 250, and snap_valid_o drops after the second pop.
- snap_ready_i=0 with three captures -> FIFO holds the first two, snap_ovf_o=1, the third is lost; the next accepted capture's delta is referenced to the second.
- FIFO full, with capture_i and snap_ready_i in the same cycle -> pop and push both succeed, and snap_ovf_o stays 0.
- lsb_cnt_err_i=1 with en_i=1 -> err_o=1 next cycle and held. err_clr_i together with a new error in the same cycle -> err_o=0. clr_i with capture_i in the same cycle -> counter 0, FIFO empty, no overflow.
